tcbm_responder: RTL and testbench

Drive-side endpoint of the TCBM parallel link: the peer of the host-side 6523 port that drives DATA[7:0] and DAV and reads ACK and STATUS[1:0]. Decodes each two-phase host transaction (code byte, then data byte), hands written bytes to the local drive logic and returns read bytes with a 2-bit status. Sits between the TCBM connector pins and the drive controller's byte interface.

---
 rtl/tcbm_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_tcbm_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcbm_responder.sv
// tcbm_responder
// Drive-side endpoint of the TCBM parallel link. It decodes two-phase host
// transactions (code byte, then data byte), passes written bytes to the local
// drive logic, and returns read bytes with a 2-bit status.
//
// Ports:
//   clock, _reset             system clock, asynchronous active-low reset
//   tcbm_data_in              DATA bus at the pins (sampled unsynchronized)
//   tcbm_data_out/_oe         DATA value toward the host and its output enable
//   tcbm_dav                  host DAV, active low, asynchronous to clock
//   tcbm_ack                  device ACK, active low
//   tcbm_status               STATUS[1:0] toward the host
//   rx_valid/rx_data/rx_is_cmd/rx_ready   written byte toward local logic
//   tx_valid/tx_data/tx_status/tx_ready   byte offered for a host read
//   timeout                   single-cycle pulse on a host-stall abort
//
// Optional feature: define TCBM_TIMEOUT_EN to abort host-wait states after
// TIMEOUT_CYCLES clocks without host progress. Without it, timeout is tied 0.

module tcbm_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       _reset,
    input  logic [7:0] tcbm_data_in,
    output logic [7:0] tcbm_data_out,
    output logic       tcbm_data_oe,
    input  logic       tcbm_dav,
    output logic       tcbm_ack,
    output logic [1:0] tcbm_status,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_is_cmd,
    input  logic       rx_ready,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_status,
    output logic       tx_ready,
    output logic       timeout
);

    localparam logic [7:0] CODE_CMD   = 8'h81;
    localparam logic [7:0] CODE_WRITE = 8'h82;
    localparam logic [7:0] CODE_READ  = 8'h83;

    typedef enum logic [2:0] {
        IDLE,
        CODE_ACK,
        BYTE_WAIT,
        RX_HOLD,
        RX_ACK,
        TX_WAIT,
        TX_ACK
    } state_t;

    // The counter is 16 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t     state_q, state_d;
    logic [1:0] dav_sync_q;
    logic       dav_s;
    logic [7:0] code_q, code_d;
    logic       ack_q, ack_d;
    logic       oe_q, oe_d;
    logic [7:0] data_out_q, data_out_d;
    logic [1:0] status_q, status_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_is_cmd_q, rx_is_cmd_d;
    logic       tx_ready_q, tx_ready_d;

`ifdef TCBM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        host_wait;

    // States in which the FSM is waiting on the host rather than local logic.
    assign host_wait = (state_q == CODE_ACK) || (state_q == BYTE_WAIT) ||
                       (state_q == RX_ACK)   || (state_q == TX_ACK);
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

    // DAV is asynchronous; only the second synchronizer stage is used.
    assign dav_s = dav_sync_q[1];

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        ack_d       = ack_q;
        oe_d        = oe_q;
        data_out_d  = data_out_q;
        status_d    = status_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        rx_is_cmd_d = rx_is_cmd_q;
        tx_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!dav_s) begin
                    code_d  = tcbm_data_in;
                    ack_d   = 1'b0;
                    state_d = CODE_ACK;
                end
            end
            CODE_ACK: begin
                if (dav_s) begin
                    ack_d = 1'b1;
                    if (code_q == CODE_CMD || code_q == CODE_WRITE || code_q == CODE_READ) begin
                        state_d = BYTE_WAIT;
                    end else begin
                        status_d = 2'b11;
                        state_d  = IDLE;
                    end
                end
            end
            BYTE_WAIT: begin
                if (!dav_s) begin
                    if (code_q == CODE_READ) begin
                        state_d = TX_WAIT;
                    end else begin
                        rx_data_d   = tcbm_data_in;
                        rx_is_cmd_d = (code_q == CODE_CMD);
                        rx_valid_d  = 1'b1;
                        state_d     = RX_HOLD;
                    end
                end
            end
            RX_HOLD: begin
                // ACK is withheld until local logic takes the byte.
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    ack_d      = 1'b0;
                    status_d   = 2'b00;
                    state_d    = RX_ACK;
                end
            end
            RX_ACK: begin
                if (dav_s) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            TX_WAIT: begin
                if (tx_valid) begin
                    data_out_d = tx_data;
                    oe_d       = 1'b1;
                    status_d   = tx_status;
                    ack_d      = 1'b0;
                    tx_ready_d = 1'b1;
                    state_d    = TX_ACK;
                end
            end
            TX_ACK: begin
                if (dav_s) begin
                    oe_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TCBM_TIMEOUT_EN
        // Host progress has priority; the stall counter only runs while the
        // FSM is parked in a host-wait state.
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (host_wait) begin
            if (wait_cnt_q == TIMEOUT_LAST) begin
                timeout_d  = 1'b1;
                ack_d      = 1'b1;
                oe_d       = 1'b0;
                state_d    = IDLE;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_q     <= IDLE;
            dav_sync_q  <= 2'b11;
            code_q      <= 8'h00;
            ack_q       <= 1'b1;
            oe_q        <= 1'b0;
            data_out_q  <= 8'h00;
            status_q    <= 2'b00;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_is_cmd_q <= 1'b0;
            tx_ready_q  <= 1'b0;
`ifdef TCBM_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dav_sync_q  <= {dav_sync_q[0], tcbm_dav};
            code_q      <= code_d;
            ack_q       <= ack_d;
            oe_q        <= oe_d;
            data_out_q  <= data_out_d;
            status_q    <= status_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_is_cmd_q <= rx_is_cmd_d;
            tx_ready_q  <= tx_ready_d;
`ifdef TCBM_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign tcbm_ack      = ack_q;
    assign tcbm_data_oe  = oe_q;
    assign tcbm_data_out = data_out_q;
    assign tcbm_status   = status_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_is_cmd     = rx_is_cmd_q;
    assign tx_ready      = tx_ready_q;

endmodule

// File: tb/tb_tcbm_responder.sv
// tb_tcbm_responder
// Drives host-side TCBM transactions into tcbm_responder and checks the pins
// and local byte interface against a transaction-level model: the host-visible
// status is tracked per completed transaction, and handshake edges are
// predicted from the synchronizer latency (ACK moves on the third clock edge
// after a DAV change is first driven).

module tb_tcbm_responder;

`ifdef TCBM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 65535;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tcbm_data_in;
    logic [7:0] tcbm_data_out;
    logic       tcbm_data_oe;
    logic       tcbm_dav;
    logic       tcbm_ack;
    logic [1:0] tcbm_status;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_is_cmd;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] tx_status;
    logic       tx_ready;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Activity counters sampled at each rising edge.
    int tx_ready_cycles = 0;
    int rx_valid_cycles = 0;

    // Status the host should currently read, per the transaction rules.
    logic [1:0] model_status;

    tcbm_responder #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clock        (clock),
        ._reset       (reset_n),
        .tcbm_data_in (tcbm_data_in),
        .tcbm_data_out(tcbm_data_out),
        .tcbm_data_oe (tcbm_data_oe),
        .tcbm_dav     (tcbm_dav),
        .tcbm_ack     (tcbm_ack),
        .tcbm_status  (tcbm_status),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_is_cmd    (rx_is_cmd),
        .rx_ready     (rx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_status    (tx_status),
        .tx_ready     (tx_ready),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (tx_ready === 1'b1) tx_ready_cycles++;
        if (rx_valid === 1'b1) rx_valid_cycles++;
    end

    // Advance to 1 ns after the next rising edge; all driving and sampling
    // happens there.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Code phase: DAV falls with the code, ACK falls on the third edge; DAV
    // rises, ACK rises on the third edge.
    task automatic host_code_phase(input logic [7:0] code);
        tcbm_data_in = code;
        tcbm_dav     = 1'b0;
        tick(); tick();
        vectors++;
        if (tcbm_ack !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL code_ack_early: ack=%b want 1", tcbm_ack);
        end
        tick();
        vectors++;
        if (tcbm_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL code_ack_fall: ack=%b want 0 (code %h)", tcbm_ack, code);
        end
        tcbm_dav = 1'b1;
        tick(); tick();
        tick();
        vectors++;
        if (tcbm_ack !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL code_ack_rise: ack=%b want 1 (code %h)", tcbm_ack, code);
        end
        tcbm_data_in = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] code, input logic [7:0] data, input int stall);
        logic exp_cmd;
        exp_cmd = (code == 8'h81);
        host_code_phase(code);
        tcbm_data_in = data;
        tcbm_dav     = 1'b0;
        rx_ready     = (stall == 0);
        tick(); tick(); tick();
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== data || rx_is_cmd !== exp_cmd || tcbm_ack !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rx_present: valid=%b data=%h cmd=%b ack=%b want 1 %h %b 1",
                     rx_valid, rx_data, rx_is_cmd, tcbm_ack, data, exp_cmd);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            vectors++;
            if (rx_valid !== 1'b1 || rx_data !== data || rx_is_cmd !== exp_cmd || tcbm_ack !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold: valid=%b data=%h cmd=%b ack=%b want 1 %h %b 1",
                         rx_valid, rx_data, rx_is_cmd, tcbm_ack, data, exp_cmd);
            end
            if (i == stall - 1) rx_ready = 1'b1;
        end
        tick();
        model_status = 2'b00;
        vectors++;
        if (rx_valid !== 1'b0 || tcbm_ack !== 1'b0 || tcbm_status !== model_status || rx_data !== data) begin
            miscompares++;
            $display("[TB] FAIL rx_accept: valid=%b ack=%b status=%b data=%h want 0 0 %b %h",
                     rx_valid, tcbm_ack, tcbm_status, rx_data, model_status, data);
        end
        rx_ready = 1'b0;
        tcbm_dav = 1'b1;
        tick(); tick();
        vectors++;
        if (tcbm_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rx_ack_hold: ack=%b want 0", tcbm_ack);
        end
        tick();
        vectors++;
        if (tcbm_ack !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rx_ack_rise: ack=%b want 1", tcbm_ack);
        end
    endtask

    // Read: tx_valid goes high 'delay' ticks after DAV falls. ACK falls at
    // tick max(4, delay+1): the FSM reaches TX_WAIT on the third edge and
    // loads on the first later edge that sees tx_valid.
    task automatic do_read(input logic [7:0] txd, input logic [1:0] txs, input int delay,
                           input bit reset_in_ack);
        int exp_tick;
        int seen_tick;
        int tx_before;
        exp_tick  = (delay + 1 > 4) ? delay + 1 : 4;
        seen_tick = -1;
        host_code_phase(8'h83);
        tx_before    = tx_ready_cycles;
        tcbm_data_in = 8'($urandom);
        tcbm_dav     = 1'b0;
        tx_data      = txd;
        tx_status    = txs;
        tx_valid     = (delay == 0);
        for (int k = 1; k <= 60 && seen_tick < 0; k++) begin
            tick();
            if (tcbm_ack === 1'b0) seen_tick = k;
            if (k == delay) tx_valid = 1'b1;
        end
        vectors++;
        if (seen_tick != exp_tick) begin
            miscompares++;
            $display("[TB] FAIL tx_ack_latency: tick=%0d want %0d", seen_tick, exp_tick);
        end
        if (seen_tick < 0) return;
        model_status = txs;
        vectors++;
        if (tcbm_data_oe !== 1'b1 || tcbm_data_out !== txd || tcbm_status !== model_status || tx_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tx_load: oe=%b out=%h status=%b tx_ready=%b want 1 %h %b 1",
                     tcbm_data_oe, tcbm_data_out, tcbm_status, tx_ready, txd, model_status);
        end
        tx_valid = 1'b0;
        if (reset_in_ack) begin
            #2 reset_n = 1'b0;
            #1;
            model_status = 2'b00;
            vectors++;
            if (tcbm_ack !== 1'b1 || tcbm_data_oe !== 1'b0 || tcbm_status !== model_status ||
                tcbm_data_out !== 8'h00 || tx_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_in_tx_ack: ack=%b oe=%b status=%b out=%h tx_ready=%b want 1 0 00 00 0",
                         tcbm_ack, tcbm_data_oe, tcbm_status, tcbm_data_out, tx_ready);
            end
            tcbm_dav = 1'b1;
            tick(); tick(); tick();
            reset_n = 1'b1;
            tick();
            return;
        end
        tick();
        vectors++;
        if (tx_ready !== 1'b0 || tcbm_data_oe !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tx_ready_pulse: tx_ready=%b oe=%b want 0 1", tx_ready, tcbm_data_oe);
        end
        tcbm_dav = 1'b1;
        tick(); tick();
        vectors++;
        if (tcbm_data_oe !== 1'b1 || tcbm_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tx_ack_hold: oe=%b ack=%b want 1 0", tcbm_data_oe, tcbm_ack);
        end
        tick();
        vectors++;
        if (tcbm_data_oe !== 1'b0 || tcbm_ack !== 1'b1 || tcbm_data_out !== txd || tcbm_status !== model_status) begin
            miscompares++;
            $display("[TB] FAIL tx_release: oe=%b ack=%b out=%h status=%b want 0 1 %h %b",
                     tcbm_data_oe, tcbm_ack, tcbm_data_out, tcbm_status, txd, model_status);
        end
        tick();
        vectors++;
        if (tx_ready_cycles - tx_before != 1) begin
            miscompares++;
            $display("[TB] FAIL tx_ready_count: pulses=%0d want 1", tx_ready_cycles - tx_before);
        end
    endtask

    task automatic do_unknown(input logic [7:0] code);
        int tx_before;
        int rx_before;
        tx_before = tx_ready_cycles;
        rx_before = rx_valid_cycles;
        host_code_phase(code);
        model_status = 2'b11;
        tick(); tick();
        vectors++;
        if (tcbm_status !== model_status || tcbm_ack !== 1'b1 ||
            tx_ready_cycles != tx_before || rx_valid_cycles != rx_before) begin
            miscompares++;
            $display("[TB] FAIL unknown_code: status=%b ack=%b tx=%0d rx=%0d want %b 1 0 0",
                     tcbm_status, tcbm_ack, tx_ready_cycles - tx_before,
                     rx_valid_cycles - rx_before, model_status);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        tcbm_dav     = 1'b1;
        tcbm_data_in = 8'h00;
        rx_ready     = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        tx_status    = 2'b00;
        model_status = 2'b00;
        tick(); tick();
        vectors++;
        if (tcbm_ack !== 1'b1 || tcbm_data_oe !== 1'b0 || tcbm_data_out !== 8'h00 || tcbm_status !== 2'b00 ||
            rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_is_cmd !== 1'b0 || tx_ready !== 1'b0 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: ack=%b oe=%b out=%h st=%b rxv=%b rxd=%h cmd=%b txr=%b to=%b",
                     tcbm_ack, tcbm_data_oe, tcbm_data_out, tcbm_status, rx_valid, rx_data,
                     rx_is_cmd, tx_ready, timeout);
        end
        reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_write_cmd();
        do_write(8'h81, 8'h55, 0);
    endtask

    task automatic test_read();
        do_read(8'hA5, 2'b01, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_write(8'h82, 8'h3C, 20);
    endtask

    task automatic test_unknown();
        do_unknown(8'h90);
    endtask

    task automatic test_idle_noise();
        int tx_before;
        int rx_before;
        tx_before = tx_ready_cycles;
        rx_before = rx_valid_cycles;
        tx_valid  = 1'b1;
        rx_ready  = 1'b1;
        tx_data   = 8'hEE;
        tx_status = 2'b10;
        repeat (10) tick();
        vectors++;
        if (tcbm_ack !== 1'b1 || tcbm_data_oe !== 1'b0 || tcbm_status !== model_status ||
            tx_ready_cycles != tx_before || rx_valid_cycles != rx_before) begin
            miscompares++;
            $display("[TB] FAIL idle_noise: ack=%b oe=%b status=%b tx=%0d rx=%0d want 1 0 %b 0 0",
                     tcbm_ack, tcbm_data_oe, tcbm_status, tx_ready_cycles - tx_before,
                     rx_valid_cycles - rx_before, model_status);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_tx_ack();
        do_read(8'h6B, 2'b10, 2, 1'b1);
        do_write(8'h81, 8'h12, 0);
    endtask

    task automatic test_random();
        logic [7:0] c;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: do_write(8'h81, 8'($urandom), int'($urandom_range(0, 6)));
                1: do_write(8'h82, 8'($urandom), int'($urandom_range(0, 6)));
                2: do_read(8'($urandom), 2'($urandom), int'($urandom_range(0, 8)), 1'b0);
                default: begin
                    do begin
                        c = 8'($urandom);
                    end while (c == 8'h81 || c == 8'h82 || c == 8'h83);
                    do_unknown(c);
                end
            endcase
            vectors++;
            if (tcbm_status !== model_status) begin
                miscompares++;
                $display("[TB] FAIL status_model: status=%b want %b", tcbm_status, model_status);
            end
        end
    endtask

`ifdef TCBM_TIMEOUT_EN
    // Host acknowledges nothing after the 0x82 code: it keeps DAV low.
    task automatic test_timeout();
        int seen;
        seen = -1;
        tcbm_data_in = 8'h82;
        tcbm_dav     = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (tcbm_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_code_ack: ack=%b want 0", tcbm_ack);
        end
        for (int k = 1; k <= 60 && seen < 0; k++) begin
            tick();
            if (timeout === 1'b1) seen = k;
        end
        vectors++;
        if (seen != TB_TIMEOUT || tcbm_ack !== 1'b1 || tcbm_data_oe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse: tick=%0d ack=%b oe=%b want %0d 1 0",
                     seen, tcbm_ack, tcbm_data_oe, TB_TIMEOUT);
        end
        tcbm_dav = 1'b1;
        repeat (3 * TB_TIMEOUT + 10) tick();
        vectors++;
        if (tcbm_ack !== 1'b1 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover: ack=%b timeout=%b want 1 0", tcbm_ack, timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_cmd();
        test_read();
        test_backpressure();
        test_unknown();
        test_idle_noise();
        test_reset_in_tx_ack();
        test_random();
`ifdef TCBM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
